// File: rtl/sdp_fifo_ctrl.sv
// Single-clock FIFO controller built around a registered-output simple dual-port RAM.
// The RAM read register doubles as the output stage, so capacity is 2^ADDR_WIDTH + 1.
module sdp_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CntFull = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;

  logic                  push, pop, fetch;

  // RAM port signals
  logic                  ram_wen;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_raddr;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Handshake decode; in_ready depends on registered state only.
  always_comb begin
    in_ready  = !reset && (ram_cnt_q != CntFull);
    push      = in_valid && in_ready;
    pop       = out_valid_q && out_ready;
    // Prefetch whenever the output register is empty or being drained this cycle.
    fetch     = !reset && (ram_cnt_q != '0) && (!out_valid_q || out_ready);

    ram_wen   = push;
    ram_waddr = wptr_q;
    ram_wdata = in_data;
    ram_ren   = fetch;
    ram_raddr = rptr_q;
  end

  // Next-state for pointers, occupancy and level.
  always_comb begin
    wptr_d      = push  ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d      = fetch ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    ram_cnt_d   = ram_cnt_q;
    unique case ({push, fetch})
      2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH+1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
    out_valid_d = fetch ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    level_d     = ram_cnt_d + {{ADDR_WIDTH{1'b0}}, out_valid_d};
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
    end
  end

  // RAM write port; push is already gated off during reset.
  always_ff @(posedge clock) begin
    if (ram_wen) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

  // RAM registered read port; holds its value when not enabled.
  always_ff @(posedge clock) begin
    if (ram_ren) begin
      rdata_q <= mem_q[ram_raddr];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = rdata_q;
  assign level     = level_q;

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Scoreboard bench for sdp_fifo_ctrl with a 4-entry RAM (capacity 5).
module tb_sdp_fifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sb_q[$];

  sdp_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, records handshakes that complete at the next rising edge.
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_data_q;
  always @(negedge clock) begin
    logic [DW-1:0] exp;
    if (reset === 1'b1) begin
      sb_q.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data_q));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check("pop_data", 32'(out_data), 32'(exp));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
      hold_q      = out_valid && !out_ready;
      hold_data_q = out_data;
      if (dut.ram_wen && dut.ram_ren) begin
        tests++;
        if (dut.ram_waddr == dut.ram_raddr) begin
          fails++;
          $display("FAIL collision: waddr 0x%0h raddr 0x%0h", dut.ram_waddr, dut.ram_raddr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (level == '0 && !out_valid) done = 1'b1;
      else step();
    end
    check("drain_done", 32'(done), 32'd1);
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int acc;
    bit hs;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    @(negedge clock);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Fill with the consumer stalled: five words fit.
    d = 8'h10; acc = 0; in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      hs = in_ready;
      step();
      if (hs) begin acc++; d++; in_data = d; end
      if (d > 8'h16) in_valid = 1'b0;
    end
    @(negedge clock);
    check("fill_accepted", 32'(acc), 32'd5);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_level", 32'(level), 32'd5);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_out_data", 32'(out_data), 32'h10);

    // Full plus simultaneous pop: the push is refused.
    step();
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    @(negedge clock);
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("full_pop_level", 32'(level), 32'd4);
    check("full_pop_in_ready_next", 32'(in_ready), 32'd1);
    check("full_pop_head", 32'(out_data), 32'h11);
    step();
    drain();

    // Single-word latency.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("lat_no_bypass", 32'(out_valid), 32'd0);
    step();
    @(negedge clock);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'hA5);
    step();
    @(negedge clock);
    check("lat_valid_clear", 32'(out_valid), 32'd0);
    check("lat_level", 32'(level), 32'd0);
    step();

    // Streaming through several pointer wraps.
    d = 8'h40; in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      hs = in_ready;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (level > 3'd2) check("stream_level_max", 32'(level), 32'd2);
      if (i >= 2) begin
        check("stream_gapfree", 32'(out_valid), 32'd1);
        check("stream_data", 32'(out_data), 32'(8'h40 + 8'(i - 2)));
      end
      step();
      if (hs) begin d++; in_data = d; end
    end
    drain();

    // Reset while holding three words and offering a fourth.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h31 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("pre_rst_level", 32'(level), 32'd3);
    step();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(negedge clock);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_data = 8'h78;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("after_rst_first", 32'(out_data), 32'h77);
    step();
    drain();

    // Random traffic with backpressure.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      step();
    end
    drain();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
